// File: rtl/add_seq.sv
// add_seq: byte-serial multi-precision adder controller.
// Streams NBYTES limbs (LSB first) through one 8-bit ripple adder (add_huit),
// chaining the carry between limbs, with a start/busy/done handshake.
// Optional build macro: ADD_SEQ_OVF_EN adds the 'ovf' output (signed overflow
// of the top limb). With the macro undefined the port and its logic are absent.

// 8-bit ripple-carry adder: {rout, s} = a + b + rin.
module add_huit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       rin,
    output logic [7:0] s,
    output logic       rout
);

    // Bit-by-bit ripple of the carry through the eight full adders.
    always_comb begin
        logic carry_v;
        carry_v = rin;
        s       = 8'd0;
        for (int i = 0; i < 8; i++) begin
            s[i]    = a[i] ^ b[i] ^ carry_v;
            carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
        end
        rout = carry_v;
    end

endmodule

module add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                rin,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] s,
`ifdef ADD_SEQ_OVF_EN
    output logic                ovf,
`endif
    output logic                rout
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [W-1:0]   a_sh_r;
    logic [W-1:0]   b_sh_r;
    logic [W-1:0]   acc_r;
    logic [W-1:0]   acc_next_s;
    logic           carry_r;
    logic [CW-1:0]  cnt_r;
    logic [7:0]     sum_s;
    logic           cout_s;
    logic           last_s;
`ifdef ADD_SEQ_OVF_EN
    logic           cin_msb_s;
`endif

    // The only adder in the design: current low limbs plus the chained carry.
    add_huit u_add_huit (
        .a    (a_sh_r[7:0]),
        .b    (b_sh_r[7:0]),
        .rin  (carry_r),
        .s    (sum_s),
        .rout (cout_s)
    );

    // New sum byte enters at the top of the accumulator; after NBYTES shifts
    // the LSB limb has travelled down to bit 0.
    always_comb begin
        acc_next_s = (acc_r >> 8) | (W'(sum_s) << (W - 8));
        last_s     = (cnt_r == CNT_LAST);
`ifdef ADD_SEQ_OVF_EN
        cin_msb_s  = sum_s[7] ^ a_sh_r[7] ^ b_sh_r[7];
`endif
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_ADD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ADD;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy    <= (next_state_s == ST_ADD);
            done    <= (next_state_s == ST_DONE);
        end
    end

    // Operand shift registers, carry chain, limb counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            s       <= '0;
            rout    <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= rin;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ST_ADD: begin
                    a_sh_r  <= a_sh_r >> 8;
                    b_sh_r  <= b_sh_r >> 8;
                    acc_r   <= acc_next_s;
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + CW'(1'b1);
                    if (last_s) begin
                        s    <= acc_next_s;
                        rout <= cout_s;
`ifdef ADD_SEQ_OVF_EN
                        ovf  <= cin_msb_s ^ cout_s;
`endif
                    end else begin
                        rout <= rout;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule
